// File: rtl/park_pkg.sv
// park_pkg: shared widths, default capacities and hour boundaries for the car park tracker
package park_pkg;
  localparam int CNT_W = 10;
  localparam int TOTAL_CAP = 700;
  localparam int FREE_DAY = 200;
  localparam int FREE_NIGHT = 500;
  localparam int FREE_STEP = 50;
  localparam logic [4:0] HOUR_DAY = 5'd8;
  localparam logic [4:0] HOUR_STEP = 5'd13;
  localparam logic [4:0] HOUR_NIGHT = 5'd16;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/park_capacity.sv
// park_capacity: combinational hour-of-day to public/university capacity decoder
module park_capacity
  import park_pkg::*;
#(
  parameter int TOTAL_CAP = park_pkg::TOTAL_CAP,
  parameter int FREE_DAY = park_pkg::FREE_DAY,
  parameter int FREE_NIGHT = park_pkg::FREE_NIGHT,
  parameter int FREE_STEP = park_pkg::FREE_STEP
) (
  input  logic [4:0]       hour,
  output logic [CNT_W-1:0] free_cap,
  output logic [CNT_W-1:0] uni_cap
);
  always_comb begin
    free_cap = (hour < HOUR_DAY || hour >= HOUR_NIGHT) ? cnt_t'(FREE_NIGHT) :
               (hour < HOUR_STEP) ? cnt_t'(FREE_DAY) :
               cnt_t'(FREE_DAY) + cnt_t'(FREE_STEP) * (cnt_t'(hour) - cnt_t'(HOUR_STEP - 5'd1));
    uni_cap = cnt_t'(TOTAL_CAP) - free_cap;
  end
endmodule

// File: rtl/park_controller.sv
// park_controller: edge-detected entry/exit counting and vacancy reporting for university and public pools
module park_controller
  import park_pkg::*;
#(
  parameter int TOTAL_CAP = park_pkg::TOTAL_CAP,
  parameter int FREE_DAY = park_pkg::FREE_DAY,
  parameter int FREE_NIGHT = park_pkg::FREE_NIGHT,
  parameter int FREE_STEP = park_pkg::FREE_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             car_entered,
  input  logic             is_uni_car_entered,
  input  logic             car_exited,
  input  logic             is_uni_car_exited,
  input  logic [4:0]       hour,
  output logic [CNT_W-1:0] uni_parked_car,
  output logic [CNT_W-1:0] parked_car,
  output logic [CNT_W-1:0] uni_vacated_space,
  output logic [CNT_W-1:0] vacated_space,
  output logic             uni_is_vacated_space,
  output logic             is_vacated_space,
  output logic             parking_is_vacated_space
);
  logic prev_in, prev_out;
  cnt_t free_cap, uni_cap, total_free, uni_room, pub_room;
  logic [CNT_W:0] total_sum;
  logic ent_uni, ent_pub, ext_uni, ext_pub;
  park_capacity #(
    .TOTAL_CAP(TOTAL_CAP), .FREE_DAY(FREE_DAY), .FREE_NIGHT(FREE_NIGHT), .FREE_STEP(FREE_STEP)
  ) u_cap (
    .hour(hour), .free_cap(free_cap), .uni_cap(uni_cap)
  );
  always_comb begin
    total_sum = {1'b0, uni_parked_car} + {1'b0, parked_car};
    total_free = cnt_t'((CNT_W+1)'(TOTAL_CAP) - total_sum);
    uni_room = (uni_cap > uni_parked_car) ? uni_cap - uni_parked_car : '0;
    pub_room = (free_cap > parked_car) ? free_cap - parked_car : '0;
    uni_vacated_space = (uni_room < total_free) ? uni_room : total_free;
    vacated_space = (pub_room < total_free) ? pub_room : total_free;
    uni_is_vacated_space = uni_vacated_space != '0;
    is_vacated_space = vacated_space != '0;
    parking_is_vacated_space = uni_is_vacated_space | is_vacated_space;
    ent_uni = car_entered & ~prev_in & is_uni_car_entered & uni_is_vacated_space;
    ent_pub = car_entered & ~prev_in & ~is_uni_car_entered & is_vacated_space;
    ext_uni = car_exited & ~prev_out & is_uni_car_exited & (uni_parked_car != '0);
    ext_pub = car_exited & ~prev_out & ~is_uni_car_exited & (parked_car != '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_in <= 1'b1;
      prev_out <= 1'b1;
      uni_parked_car <= '0;
      parked_car <= '0;
    end else begin
      prev_in <= car_entered;
      prev_out <= car_exited;
      uni_parked_car <= uni_parked_car + cnt_t'(ent_uni) - cnt_t'(ext_uni);
      parked_car <= parked_car + cnt_t'(ent_pub) - cnt_t'(ext_pub);
    end
  end
endmodule

// File: tb/tb_park_controller.sv
// tb_park_controller: directed table-driven check of counting, capacity by hour and corner cases
module tb_park_controller;
  logic clk = 1'b0, rst = 1'b1;
  logic car_entered = 1'b0, is_uni_car_entered = 1'b0, car_exited = 1'b0, is_uni_car_exited = 1'b0;
  logic [4:0] hour = 5'd0;
  logic [9:0] uni_parked_car, parked_car, uni_vacated_space, vacated_space;
  logic uni_is_vacated_space, is_vacated_space, parking_is_vacated_space;
  int n_checks = 0, n_fail = 0;
  typedef struct {
    logic [4:0] hour;
    int n_in;
    logic uni_in;
    int n_out;
    logic uni_out;
    int e_uni, e_pub, e_uv, e_v;
    logic [2:0] e_flags;
  } vec_t;
  vec_t vecs[13];
  int hrs[9], e_free[9];
  always #5 clk = ~clk;
  park_controller dut (
    .clk(clk), .rst(rst),
    .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
    .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
    .hour(hour),
    .uni_parked_car(uni_parked_car), .parked_car(parked_car),
    .uni_vacated_space(uni_vacated_space), .vacated_space(vacated_space),
    .uni_is_vacated_space(uni_is_vacated_space), .is_vacated_space(is_vacated_space),
    .parking_is_vacated_space(parking_is_vacated_space)
  );
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic pulse(input logic ent, input logic ex);
    @(posedge clk);
    #1 car_entered = ent;
    car_exited = ex;
    @(posedge clk);
    #1 car_entered = 1'b0;
    car_exited = 1'b0;
  endtask
  task automatic chk_all(input string tag, input int eu, input int ep, input int euv, input int ev, input logic [2:0] ef);
    @(negedge clk);
    chk({tag, " uni_parked_car"}, int'(uni_parked_car), eu);
    chk({tag, " parked_car"}, int'(parked_car), ep);
    chk({tag, " uni_vacated_space"}, int'(uni_vacated_space), euv);
    chk({tag, " vacated_space"}, int'(vacated_space), ev);
    chk({tag, " flags"}, int'({uni_is_vacated_space, is_vacated_space, parking_is_vacated_space}), int'(ef));
  endtask
  initial begin
    vecs[0]  = '{5'd0,  0,   1'b0, 0,   1'b0, 0,   0,   200, 500, 3'b111};
    vecs[1]  = '{5'd0,  150, 1'b1, 0,   1'b0, 150, 0,   50,  500, 3'b111};
    vecs[2]  = '{5'd0,  100, 1'b1, 0,   1'b0, 200, 0,   0,   500, 3'b011};
    vecs[3]  = '{5'd8,  0,   1'b0, 0,   1'b0, 200, 0,   300, 200, 3'b111};
    vecs[4]  = '{5'd8,  0,   1'b0, 150, 1'b1, 50,  0,   450, 200, 3'b111};
    vecs[5]  = '{5'd8,  0,   1'b0, 100, 1'b1, 0,   0,   500, 200, 3'b111};
    vecs[6]  = '{5'd10, 250, 1'b0, 0,   1'b0, 0,   200, 500, 0,   3'b101};
    vecs[7]  = '{5'd13, 0,   1'b0, 0,   1'b0, 0,   200, 450, 50,  3'b111};
    vecs[8]  = '{5'd16, 0,   1'b0, 0,   1'b0, 0,   200, 200, 300, 3'b111};
    vecs[9]  = '{5'd17, 300, 1'b0, 0,   1'b0, 0,   500, 200, 0,   3'b101};
    vecs[10] = '{5'd9,  0,   1'b0, 0,   1'b0, 0,   500, 200, 0,   3'b101};
    vecs[11] = '{5'd9,  250, 1'b1, 0,   1'b0, 200, 500, 0,   0,   3'b000};
    vecs[12] = '{5'd9,  1,   1'b0, 0,   1'b0, 200, 500, 0,   0,   3'b000};
    hrs = '{7, 8, 12, 13, 14, 15, 16, 24, 31};
    e_free = '{500, 200, 200, 250, 300, 350, 500, 500, 500};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    foreach (vecs[i]) begin
      hour = vecs[i].hour;
      is_uni_car_entered = vecs[i].uni_in;
      is_uni_car_exited = vecs[i].uni_out;
      for (int k = 0; k < vecs[i].n_in; k++) pulse(1'b1, 1'b0);
      for (int k = 0; k < vecs[i].n_out; k++) pulse(1'b0, 1'b1);
      chk_all($sformatf("vec%0d", i), vecs[i].e_uni, vecs[i].e_pub, vecs[i].e_uv, vecs[i].e_v, vecs[i].e_flags);
    end
    is_uni_car_entered = 1'b1;
    is_uni_car_exited = 1'b1;
    pulse(1'b1, 1'b1);
    chk_all("simul_full", 199, 500, 1, 0, 3'b101);
    pulse(1'b1, 1'b1);
    chk_all("simul_room", 199, 500, 1, 0, 3'b101);
    @(posedge clk);
    #1 rst = 1'b1;
    car_entered = 1'b1;
    car_exited = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    hour = 5'd0;
    repeat (3) @(posedge clk);
    chk_all("held_high_reset", 0, 0, 200, 500, 3'b111);
    #1 car_entered = 1'b0;
    car_exited = 1'b0;
    pulse(1'b1, 1'b0);
    chk_all("entry_after_reset", 1, 0, 199, 500, 3'b111);
    pulse(1'b0, 1'b1);
    foreach (hrs[i]) begin
      hour = 5'(hrs[i]);
      @(negedge clk);
      chk($sformatf("hour%0d vacated_space", hrs[i]), int'(vacated_space), e_free[i]);
      chk($sformatf("hour%0d uni_vacated_space", hrs[i]), int'(uni_vacated_space), 700 - e_free[i]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
